matmul_sequencer: RTL
=====================

Name: matmul_sequencer

Overview:
- Control FSM that sequences a full N x N matrix multiply C = A x B over the word-addressed operand memories.
- Per output element C[i][j], it walks the dot-product dimension k in bursts of LANES consecutive words and issues base addresses for A (row-major) and B (stored transposed, row j = column j).
- It drives accumulator framing (k_first/k_last) and the C write index, and provides a start/busy/done handshake to the host.
- It sits between the host control logic and the lane-parallel address expanders and MAC datapath.

Parameters:
- N, 128, matrix dimension; power of 2, at least 2*LANES.
- LANES, 8, words fetched per beat; power of 2, divides N.
- ADDR_W, 14, address width; must equal 2*log2(N).
- PIPE_LAT, 3, cycles from the last issued beat until the MAC result is committed; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- stall  in  1  memory not ready; freezes issue while high.
- rd_en  out  1  beat valid: operand addresses are valid this cycle.
- a_addr  out  ADDR_W  A lane-0 word address = i*N + kc*LANES.
- b_addr  out  ADDR_W  B lane-0 word address = j*N + kc*LANES.
- k_first  out  1  first beat of a dot product; clears the accumulator.
- k_last  out  1  last beat of a dot product; accumulator result is complete.
- c_addr  out  ADDR_W  C word index = i*N + j; valid with rd_en.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the final result is committed.

Behaviour:
- Reset: state=IDLE; counters i, j, kc = 0; drain counter = 0; all outputs 0.
- Counter widths: i and j are log2(N) bits; kc is log2(N/LANES) bits. Addresses are pure bit concatenation {i, kc, log2(LANES) zeros}, so no adder is needed and no overflow can occur.
- Output timing: outputs are registered-state decodes, so no combinational path runs from start to any output. rd_en = (state==RUN) && !stall is the only output with a combinational input dependency.
- IDLE:
  - start=1 → RUN on the next edge, with i, j, kc cleared.
  - start=0 → remain in IDLE.
- RUN, each cycle with stall=0: one beat is issued.
  - kc increments.
  - On kc wrap, j increments.
  - On j wrap, i increments.
- RUN, stall=1: rd_en=0. All counters and address outputs hold their values. k_first and k_last track the held kc.
- RUN exit: the final beat is (i, j, kc) = (N-1, N-1, N/LANES-1) issued with stall=0. The next state is DRAIN with the drain counter = PIPE_LAT-1. Counters wrap to 0.
- DRAIN:
  - rd_en=0; busy=1; stall is ignored.
  - The drain counter decrements each cycle.
  - At 0 → DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in this cycle is ignored.
- Beat count: total beats = N*N*N/LANES; default 262144.
- start while busy: ignored, with no restart.
- Reset asserted mid-run: immediate return to reset state. No done pulse is produced, and no partial state survives.
- Back-to-back jobs: start asserted in the first IDLE cycle after DONE begins the next job.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and run_cycles[31:0].
  - Both are cleared on the IDLE→RUN transition.
  - stall_cycles counts RUN cycles with stall=1. run_cycles counts all RUN and DRAIN cycles.
  - Both saturate at 0xFFFF_FFFF and hold their values after done.
  - Both reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package matmul_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, DONE);
  - localparams derived from N and LANES (IDX_W, KC_W, KBEATS = N/LANES);
  - the default ADDR_W.
- Sub-module matmul_idx_counter: the nested i/j/kc counter with enable input, wrap flags and last_beat flag. The FSM, drain counter and perf counters stay in the top module.

Test Plan:
- Small config (N=8, LANES=4, ADDR_W=6): reset, pulse start, no stall → 128 rd_en beats in consecutive cycles.
  - First beat: a_addr=0, b_addr=0, k_first=1.
  - Second beat: a_addr=4, b_addr=4, k_last=1, c_addr=0.
  - Third beat: b_addr=8, c_addr=1.
  - done pulses exactly PIPE_LAT+1 cycles after the last beat.
- Stall: hold stall=1 for 5 cycles at beat 3 (i=0, j=1, kc=1) → rd_en=0 and a_addr=4, b_addr=12 held for those 5 cycles; the sequence resumes with no beat skipped or duplicated; total beats stay 128.
- Mid-run reset: assert reset during beat 50 → all outputs 0 asynchronously. After release the block is in IDLE with no done pulse; a new start restarts at address 0.
- start held high throughout a job and through DONE → exactly one job runs. A new job begins only if start is high in an IDLE cycle after DONE.
- Default config (N=128, LANES=8) → 262144 beats; last beat has a_addr=0x3FF8, b_addr=0x3FF8, c_addr=0x3FFF, k_last=1.
- With MATMUL_SEQ_PERF_EN, small config, random stall at 30% → stall_cycles equals the bench-counted stall-high RUN cycles. run_cycles = 128 + stall_cycles + PIPE_LAT.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default geometry for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int N_DEF        = 128;
  localparam int LANES_DEF    = 8;
  localparam int ADDR_W_DEF   = 14;
  localparam int PIPE_LAT_DEF = 3;

  localparam int IDX_W  = $clog2(N_DEF);
  localparam int KBEATS = N_DEF / LANES_DEF;
  localparam int KC_W   = $clog2(KBEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i/j/kc beat counter; kc is innermost, i outermost. All fields are
// powers of two, so each one wraps to zero on its own.
module matmul_idx_counter #(
  parameter int IW = 7,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [KW-1:0] kc,
  output logic          kc_wrap,
  output logic          last_beat
);

  assign kc_wrap   = &kc;
  assign last_beat = kc_wrap && (&j) && (&i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i  <= '0;
      j  <= '0;
      kc <= '0;
    end else if (clear) begin
      i  <= '0;
      j  <= '0;
      kc <= '0;
    end else if (en) begin
      kc <= kc + 1'b1;
      if (kc_wrap) begin
        j <= j + 1'b1;
        if (&j) begin
          i <= i + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM sequencing C = A x B in LANES-wide bursts over the dot-product dimension.
// Optional MATMUL_SEQ_PERF_EN adds stall_cycles/run_cycles performance counters.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              k_first,
  output logic              k_last,
  output logic [ADDR_W-1:0] c_addr,
  output logic              busy,
  output logic              done
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       run_cycles
`endif
);

  localparam int IW = $clog2(N);
  localparam int KW = $clog2(N / LANES);
  localparam int LW = $clog2(LANES);

  state_t      state_reg;
  logic [3:0]  drain_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [IW-1:0] i_idx;
  logic [IW-1:0] j_idx;
  logic [KW-1:0] kc_idx;
  logic          kc_wrap;
  logic          last_beat;
  logic          running;
  logic          issue;
  logic          launch;

  assign running = (state_reg == RUN);
  assign issue   = running && !stall;
  assign launch  = (state_reg == IDLE) && start;

  matmul_idx_counter #(
    .IW (IW),
    .KW (KW)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .en        (issue),
    .clear     (launch),
    .i         (i_idx),
    .j         (j_idx),
    .kc        (kc_idx),
    .kc_wrap   (kc_wrap),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      drain_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (issue && last_beat) begin
            state_reg <= DRAIN;
            drain_reg <= 4'(PIPE_LAT - 1);
          end
        end
        DRAIN: begin
          // Hold off done until the MAC pipeline has committed the final result
          if (drain_reg == 4'd0) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_reg <= drain_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Addresses are bit concatenations: row index, burst index, then lane offset zeros
  assign rd_en   = issue;
  assign a_addr  = {i_idx, kc_idx, {LW{1'b0}}};
  assign b_addr  = {j_idx, kc_idx, {LW{1'b0}}};
  assign c_addr  = {i_idx, j_idx};
  assign k_first = running && (kc_idx == '0);
  assign k_last  = running && kc_wrap;
  assign busy    = busy_reg;
  assign done    = done_reg;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] run_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      run_cnt_reg   <= '0;
    end else if (launch) begin
      stall_cnt_reg <= '0;
      run_cnt_reg   <= '0;
    end else if (running || (state_reg == DRAIN)) begin
      if (run_cnt_reg != 32'hFFFF_FFFF) begin
        run_cnt_reg <= run_cnt_reg + 32'd1;
      end
      if (running && stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign run_cycles   = run_cnt_reg;
`endif

endmodule
